vga_scanout: RTL



---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/vga_scanout_if.sv | 43 ++++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_scanout.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA scan-out engine.
// Optional build macro VGA_SCANOUT_PATTERN_EN adds colour-bar fields to the control bundle.
package vga_pkg;

  localparam int R5_W     = 5;
  localparam int G6_W     = 6;
  localparam int B5_W     = 5;
  localparam int RGB565_W = R5_W + G6_W + B5_W;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    int h_act;
    int h_front;
    int h_sync;
    int h_back;
    int v_act;
    int v_front;
    int v_sync;
    int v_back;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_act: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_act: 480, v_front: 10, v_sync: 2,  v_back: 33
  };

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // Control bundle travelling alongside the pixel; sync bits mean "sync asserted",
  // polarity is applied only at the pins so the all-zero value is the idle state.
  typedef struct packed {
`ifdef VGA_SCANOUT_PATTERN_EN
    logic       pat;
    logic [2:0] bar;
`endif
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
  } pix_ctl_t;

  function automatic rgb888_t rgb565_to_888(input logic [RGB565_W-1:0] p);
    logic [R5_W-1:0] r;
    logic [G6_W-1:0] g;
    logic [B5_W-1:0] b;
    rgb888_t         o;
    {r, g, b} = p;
    o.r = {r, r[4:2]};
    o.g = {g, g[5:4]};
    o.b = {b, b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer fetch port plus VGA connector pins of the scan-out engine.
// With VGA_SCANOUT_PATTERN_EN defined the bundle also carries pattern_en.
interface vga_scanout_if #(
  parameter int ADDR_W = 19
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [15:0]       in_pixel;
  logic              VGA_HS;
  logic              VGA_VS;
  logic              VGA_BLANK_N;
  logic              VGA_SYNC_N;
  logic [7:0]        VGA_R;
  logic [7:0]        VGA_G;
  logic [7:0]        VGA_B;
  logic              frame_start;
  logic              line_start;
`ifdef VGA_SCANOUT_PATTERN_EN
  logic              pattern_en;

  modport master (
    output fetch_req, fetch_addr, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
           VGA_R, VGA_G, VGA_B, frame_start, line_start,
    input  in_pixel, pattern_en
  );
  modport slave (
    input  fetch_req, fetch_addr, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
           VGA_R, VGA_G, VGA_B, frame_start, line_start,
    output in_pixel, pattern_en
  );
`else
  modport master (
    output fetch_req, fetch_addr, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
           VGA_R, VGA_G, VGA_B, frame_start, line_start,
    input  in_pixel
  );
  modport slave (
    input  fetch_req, fetch_addr, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
           VGA_R, VGA_G, VGA_B, frame_start, line_start,
    output in_pixel
  );
`endif
endinterface

// File: rtl/vga_delay_line.sv
// W-bit x D-deep register shift line; every stage resets asynchronously to RST_VAL.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             D       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [D-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {D{RST_VAL}};
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[D-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: timing counters, linear framebuffer fetch, RGB565->888 expansion.
// Build macro VGA_SCANOUT_PATTERN_EN adds an 8-bar colour test pattern selected by pattern_en.
module vga_scanout import vga_pkg::*; #(
  parameter int H_ACT   = VGA_640X480_60.h_act,
  parameter int H_FRONT = VGA_640X480_60.h_front,
  parameter int H_SYNC  = VGA_640X480_60.h_sync,
  parameter int H_BACK  = VGA_640X480_60.h_back,
  parameter int V_ACT   = VGA_640X480_60.v_act,
  parameter int V_FRONT = VGA_640X480_60.v_front,
  parameter int V_SYNC  = VGA_640X480_60.v_sync,
  parameter int V_BACK  = VGA_640X480_60.v_back,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int PIX_LAT = 2,
  parameter int ADDR_W  = 19
) (
  input  logic           clk_pix,
  input  logic           rst_n,
  vga_scanout_if.master  bus
);

  localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACT);
  localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACT + H_FRONT);
  localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACT);
  localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACT + V_FRONT);
  localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACT + V_FRONT + V_SYNC);

  if (longint'(H_ACT) * longint'(V_ACT) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("vga_scanout: H_ACT*V_ACT does not fit in ADDR_W address bits");
  end
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_lat_chk
    $error("vga_scanout: PIX_LAT must be 1..4");
  end

  // ---------------- timing counters ----------------
  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic            h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hc_q == HC_LAST);
    v_wrap = (vc_q == VC_LAST);
    hc_d   = h_wrap ? '0 : hc_q + 1'b1;
    vc_d   = vc_q;
    if (h_wrap) vc_d = v_wrap ? '0 : vc_q + 1'b1;
  end

`ifdef VGA_SCANOUT_PATTERN_EN
  localparam int               BAR_W    = H_ACT / 8;
  localparam int               BPX_W    = $clog2(BAR_W + 1);
  localparam logic [BPX_W-1:0] BPX_LAST = BPX_W'(BAR_W - 1);

  if (H_ACT % 8 != 0) begin : g_bar_chk
    $error("vga_scanout: H_ACT must be a multiple of 8 for the bar pattern");
  end

  // Bar position tracks hc without a divider: pixel-in-bar and bar index counters.
  logic [BPX_W-1:0] bar_px_q;
  logic [2:0]       bar_idx_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else if (h_wrap) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else if (hc_q < HC_ACT) begin
      if (bar_px_q == BPX_LAST) begin
        bar_px_q  <= '0;
        bar_idx_q <= bar_idx_q + 1'b1;
      end else begin
        bar_px_q  <= bar_px_q + 1'b1;
      end
    end
  end
`endif

  pix_ctl_t ctl_c, ctl_q, ctl_dl;

  always_comb begin
    ctl_c     = '0;
    ctl_c.act = (hc_q < HC_ACT) && (vc_q < VC_ACT);
    ctl_c.hs  = (hc_q >= HS_BEG) && (hc_q < HS_END);
    ctl_c.vs  = (vc_q >= VS_BEG) && (vc_q < VS_END);
    ctl_c.ls  = ctl_c.act && (hc_q == '0);
    ctl_c.fs  = ctl_c.ls && (vc_q == '0);
`ifdef VGA_SCANOUT_PATTERN_EN
    ctl_c.pat = bus.pattern_en;
    ctl_c.bar = bar_idx_q;
`endif
  end

  // ---------------- fetch stage ----------------
  logic              fetch_req_q;
  logic [ADDR_W-1:0] fetch_addr_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hc_q         <= '0;
      vc_q         <= '0;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= '0;
      ctl_q        <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      fetch_req_q <= ctl_c.act;
      ctl_q       <= ctl_c;
      // Address is the running fetch count; the frame wrap rewinds it for the next frame.
      if (h_wrap && v_wrap)  fetch_addr_q <= '0;
      else if (fetch_req_q)  fetch_addr_q <= fetch_addr_q + 1'b1;
    end
  end

  // Control waits PIX_LAT cycles so it lines up with the returning in_pixel.
  vga_delay_line #(
    .W       ($bits(pix_ctl_t)),
    .D       (PIX_LAT),
    .RST_VAL ('0)
  ) u_dly (
    .clk   (clk_pix),
    .rst_n (rst_n),
    .d_i   (ctl_q),
    .q_o   (ctl_dl)
  );

  // ---------------- display stage ----------------
  rgb888_t rgb_d, rgb_q;
  logic    hs_q, vs_q, blank_n_q, fs_q, ls_q;

  always_comb begin
    rgb_d = rgb565_to_888(bus.in_pixel);
`ifdef VGA_SCANOUT_PATTERN_EN
    if (ctl_dl.pat) rgb_d = rgb888_t'(BAR_RGB[ctl_dl.bar]);
`endif
    if (!ctl_dl.act) rgb_d = '0;
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      hs_q      <= ctl_dl.hs ? HS_POL : ~HS_POL;
      vs_q      <= ctl_dl.vs ? VS_POL : ~VS_POL;
      blank_n_q <= ctl_dl.act;
      rgb_q     <= rgb_d;
      fs_q      <= ctl_dl.fs;
      ls_q      <= ctl_dl.ls;
    end
  end

  assign bus.fetch_req   = fetch_req_q;
  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLANK_N = blank_n_q;
  assign bus.VGA_SYNC_N  = 1'b1;
  assign bus.VGA_R       = rgb_q.r;
  assign bus.VGA_G       = rgb_q.g;
  assign bus.VGA_B       = rgb_q.b;
  assign bus.frame_start = fs_q;
  assign bus.line_start  = ls_q;

endmodule
